// File: rtl/cm_nway.sv
// ============================================================================
// cm_nway : N-way round-robin token merge with tagged DEPTH-entry output FIFO
// Optional macro: CM_NWAY_FIXED_PRIO_EN selects fixed lowest-index priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cm_nway #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int SW   = $clog2(N),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           CLK,
    input  logic           MR_N,
    input  logic [N-1:0]   Send_in,
    input  logic [N*W-1:0] Data_in,
    output logic [N-1:0]   Ack_out,
    output logic           Send_out,
    output logic [W-1:0]   Data_out,
    output logic [SW-1:0]  Sel_out,
    input  logic           Ack_in,
    output logic [N-1:0]   CP,
    output logic [CW-1:0]  Count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_data_q [DEPTH];
    logic [W-1:0]  mem_data_d [DEPTH];
    logic [SW-1:0] mem_sel_q  [DEPTH];
    logic [SW-1:0] mem_sel_d  [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  cp_q, cp_d;

    logic [SW-1:0] grant_idx;
    logic          found;
    logic          not_full;
    logic          push;
    logic          pop;

    assign not_full = (count_q < CW'(DEPTH));

`ifdef CM_NWAY_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the final winner.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (Send_in[i]) begin
                grant_idx = SW'(i);
                found     = 1'b1;
            end
        end
    end
`else
    logic [SW-1:0] ptr_q, ptr_d;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && Send_in[(int'(ptr_q) + k) % N]) begin
                grant_idx = SW'((int'(ptr_q) + k) % N);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (push) begin
            ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
        end
    end

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // MR_N gating keeps Ack_out low for the whole reset interval.
    assign Ack_out = (found && not_full && MR_N) ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign push    = |Ack_out;
    assign pop     = (count_q != '0) && Ack_in;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_sel_d  = mem_sel_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        cp_d       = Ack_out;
        if (push) begin
            mem_data_d[wr_q] = Data_in[int'(grant_idx) * W +: W];
            mem_sel_d[wr_q]  = grant_idx;
            wr_d             = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_sel_q[i]  <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cp_q    <= '0;
        end else begin
            mem_data_q <= mem_data_d;
            mem_sel_q  <= mem_sel_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            cp_q       <= cp_d;
        end
    end

    assign Send_out = (count_q != '0);
    assign Data_out = Send_out ? mem_data_q[rd_q] : '0;
    assign Sel_out  = Send_out ? mem_sel_q[rd_q]  : '0;
    assign CP       = cp_q;
    assign Count    = count_q;

endmodule

`default_nettype wire
